// File: rtl/serial_borrow_subtractor_if.sv
// Operand/result handshake bundle for serial_borrow_subtractor.
// Defining SUB_OVERFLOW_EN adds the signed overflow flag to the result side.
interface serial_borrow_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out
`ifdef SUB_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out
`ifdef SUB_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial a - b - borrow_in, one bit per clock LSB first, with valid/ready on both sides.
// Optional SUB_OVERFLOW_EN adds a registered two's-complement overflow flag.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_borrow_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef SUB_OVERFLOW_EN
  logic             overflow_q;
`endif

  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell working on the current LSBs of the operand shifters.
  always_comb begin
    bit_d    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = {bit_d, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      br          <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            br         <= bus.borrow_in;
            res_sh     <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          // On the MSB cycle br still holds the borrow into the MSB.
          if (cnt == LAST_BIT) begin
            diff_q      <= res_next;
            borrow_q    <= br_next;
`ifdef SUB_OVERFLOW_EN
            overflow_q  <= br ^ br_next;
`endif
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench: WIDTH=4 vector table plus corner sequences, and a WIDTH=8 model sweep.
// Results are checked through per-DUT expectation queues popped on each output handshake.
module tb_serial_borrow_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t e4;
  exp_t e8;
  vec_t vecs[11];

  serial_borrow_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_borrow_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_borrow_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_borrow_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv, input logic bin);
    exp_t r;
    int   sd;
    sd     = int'(signed'(av)) - int'(signed'(bv)) - int'(bin);
    r.diff = 8'(int'(av) - int'(bv) - int'(bin));
    r.bout = (int'(av) < int'(bv) + int'(bin));
    r.ovf  = (sd < -128) || (sd > 127);
    return r;
  endfunction

  // Scoreboards: one result is due whenever the next edge completes an output handshake.
  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      checkOutput("w4 scoreboard nonempty", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        checkOutput("w4 diff", 32'(bus4.diff), 32'(e4.diff[3:0]));
        checkOutput("w4 borrow_out", 32'(bus4.borrow_out), 32'(e4.bout));
`ifdef SUB_OVERFLOW_EN
        checkOutput("w4 overflow", 32'(bus4.overflow), 32'(e4.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      checkOutput("w8 scoreboard nonempty", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        checkOutput("w8 diff", 32'(bus8.diff), 32'(e8.diff));
        checkOutput("w8 borrow_out", 32'(bus8.borrow_out), 32'(e8.bout));
`ifdef SUB_OVERFLOW_EN
        checkOutput("w8 overflow", 32'(bus8.overflow), 32'(e8.ovf));
`endif
      end
    end
  end

  // Runs one WIDTH=4 operation; stall holds out_ready low in DONE, junk keeps in_valid high with other operands.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic bin,
                               input int stall, input bit junk, input exp_t e);
    int n;
    int lat;
    bit ir_bad;
    n = 0;
    while (!bus4.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w4 in_ready before accept", 32'(bus4.in_ready), 1);
    bus4.a         = av;
    bus4.b         = bv;
    bus4.borrow_in = bin;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = (stall == 0);
    q4.push_back(e);
    @(posedge clk); #1;
    if (junk) begin
      bus4.a         = ~av;
      bus4.b         = ~bv;
      bus4.borrow_in = ~bin;
    end else begin
      bus4.in_valid = 1'b0;
    end
    lat    = 0;
    ir_bad = 1'b0;
    while (!bus4.out_valid && lat < 16) begin
      if (bus4.in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w4 latency", 32'(lat), 4);
    checkOutput("w4 in_ready low in RUN", 32'(ir_bad), 0);
    for (int s = 0; s < stall; s++) begin
      checkOutput("w4 held out_valid", 32'(bus4.out_valid), 1);
      checkOutput("w4 held diff", 32'(bus4.diff), 32'(e.diff[3:0]));
      checkOutput("w4 held borrow_out", 32'(bus4.borrow_out), 32'(e.bout));
      checkOutput("w4 in_ready low in DONE", 32'(bus4.in_ready), 0);
      @(posedge clk); #1;
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    checkOutput("w4 out_valid drops", 32'(bus4.out_valid), 0);
    checkOutput("w4 in_ready after consume", 32'(bus4.in_ready), 1);
  endtask

  task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv, input logic bin);
    int n;
    int lat;
    n = 0;
    while (!bus8.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w8 in_ready before accept", 32'(bus8.in_ready), 1);
    bus8.a         = av;
    bus8.b         = bv;
    bus8.borrow_in = bin;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    q8.push_back(model8(av, bv, bin));
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w8 latency", 32'(lat), 8);
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] corners[6];
    exp_t       e;

    corners = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
    vecs[0]  = '{8'd9,  8'd3,  1'b0, 8'd6,  1'b0, 1'b1};
    vecs[1]  = '{8'd3,  8'd9,  1'b0, 8'd10, 1'b1, 1'b1};
    vecs[2]  = '{8'd0,  8'd0,  1'b1, 8'd15, 1'b1, 1'b0};
    vecs[3]  = '{8'd8,  8'd1,  1'b0, 8'd7,  1'b0, 1'b1};
    vecs[4]  = '{8'd7,  8'd1,  1'b0, 8'd6,  1'b0, 1'b0};
    vecs[5]  = '{8'd15, 8'd15, 1'b1, 8'd15, 1'b1, 1'b0};
    vecs[6]  = '{8'd5,  8'd5,  1'b0, 8'd0,  1'b0, 1'b0};
    vecs[7]  = '{8'd0,  8'd15, 1'b0, 8'd1,  1'b1, 1'b0};
    vecs[8]  = '{8'd15, 8'd0,  1'b1, 8'd14, 1'b0, 1'b0};
    vecs[9]  = '{8'd7,  8'd8,  1'b0, 8'd15, 1'b1, 1'b1};
    vecs[10] = '{8'd10, 8'd3,  1'b1, 8'd6,  1'b0, 1'b1};

    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0; bus4.borrow_in = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.borrow_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(bus4.out_valid), 0);
    checkOutput("reset in_ready", 32'(bus4.in_ready), 1);
    checkOutput("reset diff", 32'(bus4.diff), 0);
    checkOutput("reset borrow_out", 32'(bus4.borrow_out), 0);
    checkOutput("reset w8 in_ready", 32'(bus8.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      e = '{vecs[i].diff, vecs[i].bout, vecs[i].ovf};
      applyStimulus(vecs[i].a[3:0], vecs[i].b[3:0], vecs[i].bin, 0, 1'b0, e);
    end

    // Backpressure with in_valid left high: result must hold and nothing new may be captured.
    applyStimulus(4'd12, 4'd5, 1'b0, 3, 1'b1, '{8'd7, 1'b0, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    checkOutput("no capture after backpressure", 32'(bus4.out_valid), 0);

    // Reset during the second RUN cycle abandons the operation.
    bus4.a = 4'd9; bus4.b = 4'd3; bus4.borrow_in = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrun reset out_valid", 32'(bus4.out_valid), 0);
    checkOutput("midrun reset in_ready", 32'(bus4.in_ready), 1);
    checkOutput("midrun reset diff", 32'(bus4.diff), 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no partial result", 32'(bus4.out_valid), 0);
    applyStimulus(4'd7, 4'd2, 1'b0, 0, 1'b0, '{8'd5, 1'b0, 1'b0});

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int k = 0; k < 2; k++)
          applyStimulus8(corners[i], corners[j], k[0]);
    for (int n = 0; n < 150; n++)
      applyStimulus8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("w4 scoreboard drained", 32'(q4.size()), 0);
    checkOutput("w8 scoreboard drained", 32'(q8.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
